// File: rtl/vx_tcu_csr_tile_buf_if.sv
// Bundle of the fill, read, write and drain handshakes between the tile buffer
// and its clients (LSU load/store path and TCU controller).
interface vx_tcu_csr_tile_buf_if #(
  parameter int TILE_ELEMS = 4,
  parameter int DATAW      = 32
);
  localparam int IDXW = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;

  // valid/ready: a transfer happens on a rising clk edge where both are 1;
  // the source holds its payload stable while valid=1 and ready=0.
  logic             fill_valid;
  logic             fill_ready;
  logic             fill_sel;
  logic [IDXW-1:0]  fill_idx;
  logic [DATAW-1:0] fill_data;
  logic             ab_loaded;

  logic             read_enable;
  logic             read_valid;
  logic [DATAW-1:0] read_data_a;
  logic [DATAW-1:0] read_data_b;
  logic             read_last;

  logic             write_enable;
  logic [DATAW-1:0] write_data;
  logic             write_done;

  logic             drain_valid;
  logic             drain_ready;
  logic [DATAW-1:0] drain_data;
  logic             drain_last;

  logic             tile_busy;

  modport master (
    output fill_valid, fill_sel, fill_idx, fill_data,
    output read_enable, write_enable, write_data, drain_ready,
    input  fill_ready, ab_loaded, read_valid, read_data_a, read_data_b, read_last,
    input  write_done, drain_valid, drain_data, drain_last, tile_busy
  );

  modport slave (
    input  fill_valid, fill_sel, fill_idx, fill_data,
    input  read_enable, write_enable, write_data, drain_ready,
    output fill_ready, ab_loaded, read_valid, read_data_a, read_data_b, read_last,
    output write_done, drain_valid, drain_data, drain_last, tile_busy
  );
endinterface

// File: rtl/vx_tcu_csr_tile_buf.sv
// Single A/B operand tile plus C result tile for the tensor core: filled from LSU
// loads, streamed to the TCU, refilled with C results, then drained to the store path.
module vx_tcu_csr_tile_buf #(
  parameter int TILE_ELEMS = 4,
  parameter int DATAW      = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  vx_tcu_csr_tile_buf_if.slave    bus,
  output logic [1:0]              dbg_state
);
  localparam int IDXW = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TILE_ELEMS - 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           state;
  logic [TILE_ELEMS-1:0] a_vld, b_vld, a_vld_nxt, b_vld_nxt;
  logic [IDXW-1:0]  rd_ptr, wr_ptr, dr_ptr;
  logic [DATAW-1:0] tile_a [TILE_ELEMS];
  logic [DATAW-1:0] tile_b [TILE_ELEMS];
  logic [DATAW-1:0] tile_c [TILE_ELEMS];

  logic             fill_rdy_q, ab_loaded_q, rd_valid_q, rd_last_q, wr_done_q;
  logic [DATAW-1:0] rd_a_q, rd_b_q;
  logic             fill_fire, rd_fire, wr_fire, dr_fire;

  assign fill_fire = bus.fill_valid & fill_rdy_q;
  assign rd_fire   = (state == S_READ)  & bus.read_enable;
  assign wr_fire   = (state == S_WRITE) & bus.write_enable;
  assign dr_fire   = (state == S_DRAIN) & bus.drain_ready;

  always_comb begin
    a_vld_nxt = a_vld;
    b_vld_nxt = b_vld;
    if (fill_fire) begin
      if (bus.fill_sel) b_vld_nxt[bus.fill_idx] = 1'b1;
      else              a_vld_nxt[bus.fill_idx] = 1'b1;
    end
  end

  // Tile storage carries no reset; validity is tracked by the vld bits.
  always_ff @(posedge clk) begin
    if (fill_fire) begin
      if (bus.fill_sel) tile_b[bus.fill_idx] <= bus.fill_data;
      else              tile_a[bus.fill_idx] <= bus.fill_data;
    end
    if (wr_fire) tile_c[wr_ptr] <= bus.write_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_FILL;
      a_vld       <= '0;
      b_vld       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      dr_ptr      <= '0;
      fill_rdy_q  <= 1'b0;
      ab_loaded_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      wr_done_q   <= 1'b0;
      rd_a_q      <= '0;
      rd_b_q      <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      wr_done_q  <= 1'b0;
      fill_rdy_q <= (state == S_FILL);
      case (state)
        S_FILL: begin
          a_vld <= a_vld_nxt;
          b_vld <= b_vld_nxt;
          if (fill_fire && (&a_vld_nxt) && (&b_vld_nxt)) begin
            state       <= S_READ;
            ab_loaded_q <= 1'b1;
            fill_rdy_q  <= 1'b0;
          end
        end
        S_READ: begin
          if (rd_fire) begin
            rd_valid_q <= 1'b1;
            rd_a_q     <= tile_a[rd_ptr];
            rd_b_q     <= tile_b[rd_ptr];
            rd_last_q  <= (rd_ptr == LAST_IDX);
            rd_ptr     <= rd_ptr + IDXW'(1);
            if (rd_ptr == LAST_IDX) state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (wr_fire) begin
            wr_ptr <= wr_ptr + IDXW'(1);
            if (wr_ptr == LAST_IDX) begin
              wr_done_q <= 1'b1;
              state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (dr_fire) begin
            dr_ptr <= dr_ptr + IDXW'(1);
            // Last store hand-off recycles the buffer for the next tile.
            if (dr_ptr == LAST_IDX) begin
              state       <= S_FILL;
              fill_rdy_q  <= 1'b1;
              a_vld       <= '0;
              b_vld       <= '0;
              rd_ptr      <= '0;
              wr_ptr      <= '0;
              dr_ptr      <= '0;
              ab_loaded_q <= 1'b0;
            end
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

  assign bus.fill_ready  = fill_rdy_q;
  assign bus.ab_loaded   = ab_loaded_q;
  assign bus.read_valid  = rd_valid_q;
  assign bus.read_data_a = rd_a_q;
  assign bus.read_data_b = rd_b_q;
  assign bus.read_last   = rd_last_q;
  assign bus.write_done  = wr_done_q;
  assign bus.drain_valid = (state == S_DRAIN);
  assign bus.drain_data  = (state == S_DRAIN) ? tile_c[dr_ptr] : '0;
  assign bus.drain_last  = (state == S_DRAIN) && (dr_ptr == LAST_IDX);
  assign bus.tile_busy   = (state != S_FILL);
  assign dbg_state       = state;
endmodule

// File: tb/tb_vx_tcu_csr_tile_buf.sv
// Scoreboard bench for vx_tcu_csr_tile_buf: random tiles, array reference model,
// expected queues for read pairs and drained C elements.
module tb_vx_tcu_csr_tile_buf;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;

  always #5 clk = ~clk;

  vx_tcu_csr_tile_buf_if #(.TILE_ELEMS(N), .DATAW(DW)) bus ();
  vx_tcu_csr_tile_buf #(.TILE_ELEMS(N), .DATAW(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .dbg_state(dbg_state)
  );

  // Reference model: tile contents as the spec defines them, plus order of fills.
  logic [DW-1:0] a_m [N];
  logic [DW-1:0] b_m [N];
  logic [DW-1:0] c_m [N];
  logic [DW-1:0] src_a [N];
  logic [DW-1:0] src_b [N];
  logic [DW-1:0] src_c [N];
  int            ord_q [$];
  logic [DW-1:0] val_q [$];
  logic [2*DW:0] exp_rd_q [$];
  logic [DW:0]   exp_dr_q [$];
  int            rdy_q [$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents read or drain data.
  logic          prev_stall = 1'b0;
  logic [DW:0]   prev_dr;
  logic [2*DW:0] e_rd;
  logic [DW:0]   e_dr;
  always @(negedge clk) begin
    if (!reset) prev_stall = 1'b0;
    else begin
      if (bus.read_valid) begin
        if (exp_rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          e_rd = exp_rd_q.pop_front();
          check("rd_pair", {bus.read_data_a, bus.read_data_b, bus.read_last}, e_rd);
        end
      end
      if (bus.write_done) done_cnt++;
      if (bus.drain_valid) begin
        if (prev_stall) check("dr_stable", {bus.drain_data, bus.drain_last}, prev_dr);
        if (bus.drain_ready) begin
          if (exp_dr_q.size() == 0) check("dr_unexpected", 1, 0);
          else begin
            e_dr = exp_dr_q.pop_front();
            check("dr_elem", {bus.drain_data, bus.drain_last}, e_dr);
          end
        end
        prev_stall = !bus.drain_ready;
        prev_dr    = {bus.drain_data, bus.drain_last};
      end else begin
        check("dr_idle_zero", {bus.drain_data, bus.drain_last}, 0);
        prev_stall = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fill_valid = 0; bus.fill_sel = 0; bus.fill_idx = '0; bus.fill_data = '0;
    bus.read_enable = 0; bus.write_enable = 0; bus.write_data = '0; bus.drain_ready = 0;
  endtask

  task automatic build_fill(input bit dup_a0);
    int p [2*N];
    int j, t;
    ord_q.delete(); val_q.delete();
    for (int i = 0; i < N; i++) begin
      src_a[i] = $urandom; src_b[i] = $urandom; src_c[i] = $urandom;
    end
    for (int i = 0; i < 2*N; i++) p[i] = i;
    for (int i = 2*N-1; i > 0; i--) begin
      j = $urandom_range(0, i); t = p[i]; p[i] = p[j]; p[j] = t;
    end
    if (dup_a0) begin
      src_a[0] = 7; src_b[0] = 10;
      ord_q.push_back(0); val_q.push_back(5);
    end
    for (int i = 0; i < 2*N; i++) begin
      if (!(dup_a0 && p[i] == 0)) ord_q.push_back(p[i]);
      else continue;
      val_q.push_back(p[i] < N ? src_a[p[i]] : src_b[p[i]-N]);
    end
    if (dup_a0) begin
      ord_q.push_front(0); val_q.push_front(0);
      ord_q[1] = 0; val_q[1] = 7;
      ord_q[0] = 0; val_q[0] = 5;
    end
  endtask

  task automatic fill_tile(input bit stray);
    bit seen [2*N];
    int distinct = 0;
    int d0 = done_cnt;
    bit done_now;
    for (int i = 0; i < 2*N; i++) seen[i] = 0;
    for (int k = 0; k < ord_q.size(); k++) begin
      bus.fill_valid = 1;
      bus.fill_sel   = (ord_q[k] >= N);
      bus.fill_idx   = IW'(ord_q[k] % N);
      bus.fill_data  = val_q[k];
      bus.read_enable  = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.write_enable = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      if (ord_q[k] >= N) b_m[ord_q[k]-N] = val_q[k]; else a_m[ord_q[k]] = val_q[k];
      done_now = !seen[ord_q[k]] && (distinct == 2*N-1);
      if (!seen[ord_q[k]]) begin seen[ord_q[k]] = 1; distinct++; end
      check("fill_ready", bus.fill_ready, 1);
      check("ab_not_yet", bus.ab_loaded, 0);
      cyc();
      idle_inputs();
      if (done_now) begin
        check("ab_loaded", bus.ab_loaded, 1);
        check("fill_ready_off", bus.fill_ready, 0);
        check("state_read", dbg_state, 1);
        check("busy_read", bus.tile_busy, 1);
      end
    end
    check("no_stray_done", done_cnt - d0, 0);
  endtask

  task automatic read_tile(input bit b2b, input bit stray_wr);
    for (int i = 0; i < N; i++) begin
      if (!b2b && $urandom_range(0, 1) == 1) begin
        cyc();
        check("rd_idle", bus.read_valid, 0);
      end
      bus.read_enable  = 1;
      bus.write_enable = stray_wr;
      bus.write_data   = $urandom;
      exp_rd_q.push_back({a_m[i], b_m[i], 1'(i == N-1)});
      cyc();
      bus.read_enable = 0; bus.write_enable = 0;
      check("rd_latency", bus.read_valid, 1);
    end
    check("state_write", dbg_state, 2);
  endtask

  task automatic write_tile(input bit gap23, input bit rand_gap);
    int d0 = done_cnt;
    for (int i = 0; i < N; i++) begin
      if ((gap23 && i == 2) || (rand_gap && $urandom_range(0, 1) == 1)) begin
        bus.read_enable = 1'($urandom_range(0, 1));
        cyc();
        bus.read_enable = 0;
        check("wd_gap", bus.write_done, 0);
      end
      bus.write_enable = 1;
      bus.write_data   = src_c[i];
      c_m[i] = src_c[i];
      exp_dr_q.push_back({src_c[i], 1'(i == N-1)});
      cyc();
      bus.write_enable = 0;
      if (i == 0) check("rd_quiet_in_write", bus.read_valid, 0);
      if (i < N-1) check("wd_early", bus.write_done, 0);
      else begin
        check("wd_pulse", bus.write_done, 1);
        check("state_drain", dbg_state, 3);
      end
    end
    cyc();
    check("wd_one_cycle", bus.write_done, 0);
    check("wd_count", done_cnt - d0, 1);
  endtask

  task automatic drain_tile(input int stop_after);
    int  fires = 0;
    int  budget = 0;
    bit  f;
    while (fires < stop_after && budget < 200) begin
      bus.drain_ready = (rdy_q.size() > 0) ? 1'(rdy_q.pop_front()) : 1'($urandom_range(0, 1));
      f = bus.drain_valid && bus.drain_ready;
      cyc();
      budget++;
      if (f) fires++;
    end
    bus.drain_ready = 0;
    if (budget >= 200) check("dr_timeout", 0, 1);
    if (stop_after == N) begin
      check("idle_busy", bus.tile_busy, 0);
      check("idle_fill_ready", bus.fill_ready, 1);
      check("idle_ab", bus.ab_loaded, 0);
      check("idle_state", dbg_state, 0);
    end
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    #1;
    check("rst_fill_ready", bus.fill_ready, 0);
    check("rst_ab", bus.ab_loaded, 0);
    check("rst_busy", bus.tile_busy, 0);
    check("rst_outs", {bus.read_valid, bus.read_last, bus.write_done, bus.drain_valid, bus.drain_last}, 0);
    check("rst_drain_data", bus.drain_data, 0);
    check("rst_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    cyc();
    check("post_rst_fill_ready", bus.fill_ready, 1);

    // Directed tile: out-of-order fill, b2b reads with stray writes, gapped C writes.
    src_a = '{32'd1, 32'd2, 32'd3, 32'd4};
    src_b = '{32'd10, 32'd20, 32'd30, 32'd40};
    src_c = '{32'hA, 32'hB, 32'hC, 32'hD};
    ord_q = '{7, 0, 3, 4, 1, 5, 2, 6};
    val_q = '{32'd40, 32'd1, 32'd4, 32'd10, 32'd2, 32'd20, 32'd3, 32'd30};
    fill_tile(0);
    read_tile(1, 1);
    write_tile(1, 0);
    rdy_q = '{1, 0, 0, 1, 1, 1};
    drain_tile(N);

    // A0 rewritten (5 then 7) with stray requests during fill.
    build_fill(1);
    fill_tile(1);
    read_tile(0, 1);
    write_tile(0, 1);
    drain_tile(N);

    // Reset in the middle of a drain, then a clean tile.
    build_fill(0);
    fill_tile(1);
    read_tile(0, 0);
    write_tile(0, 1);
    drain_tile(2);
    #2 reset = 0;
    #1;
    check("mid_rst_drain_valid", bus.drain_valid, 0);
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_ab", bus.ab_loaded, 0);
    check("mid_rst_outs", {bus.read_valid, bus.write_done, bus.tile_busy}, 0);
    exp_dr_q.delete();
    @(negedge clk) reset = 1;
    cyc();
    check("rst_rel_fill_ready", bus.fill_ready, 1);

    for (int r = 0; r < 3; r++) begin
      build_fill(0);
      fill_tile(1);
      read_tile(r == 0, 1);
      write_tile(0, 1);
      drain_tile(N);
    end

    repeat (3) cyc();
    check("rd_queue_empty", exp_rd_q.size(), 0);
    check("dr_queue_empty", exp_dr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
